// File: rtl/uart_rx_word_assembler.sv
// 8N1 UART receiver that packs every four good bytes into one big-endian 32-bit word.
// Also emits per-byte, frame-error and partial-word-timeout pulses for debug.
module uart_rx_word_assembler #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        frame_err_o,
  output logic        timeout_err_o,
  output logic        busy_o
);

  localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TO_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_word;
  logic [TW-1:0] r_to_cnt;
  logic [31:0]   r_data;
  logic          r_valid;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_err;
  logic          r_timeout_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_byte_idx    <= '0;
      r_word        <= '0;
      r_to_cnt      <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_byte        <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rx_meta     <= rx_i;
      r_rx_s        <= r_rx_meta;
      r_valid       <= 1'b0;
      r_byte_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A falling edge beats a timeout landing in the same cycle.
          if (!r_rx_s) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
            r_to_cnt  <= '0;
          end else if (r_byte_idx != 2'd0 && r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_MAX - 1'b1) begin
              r_timeout_err <= 1'b1;
              r_byte_idx    <= '0;
            end
          end
        end
        S_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == BIT_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == BIT_M1) begin
            r_clk_cnt <= '0;
            r_state   <= S_IDLE;
            if (r_rx_s) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
              if (r_byte_idx == 2'd3) begin
                r_data     <= {r_word, r_shift};
                r_valid    <= 1'b1;
                r_byte_idx <= '0;
              end else begin
                r_word     <= {r_word[15:0], r_shift};
                r_byte_idx <= r_byte_idx + 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_byte_idx  <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_o        = r_data;
  assign valid_o       = r_valid;
  assign byte_o        = r_byte;
  assign byte_valid_o  = r_byte_valid;
  assign frame_err_o   = r_frame_err;
  assign timeout_err_o = r_timeout_err;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Bench for uart_rx_word_assembler: byte-level reference model with expected queues,
// per-cycle compare process, directed scenarios with literal expectations, random frames.
module tb_uart_rx_word_assembler;
  localparam int CPB = 8;
  localparam int TOB = 4;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rstn;
  logic rx_i;
  always #5 clk = ~clk;

  logic [31:0] data_o;
  logic        valid_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        frame_err_o;
  logic        timeout_err_o;
  logic        busy_o;

  uart_rx_word_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rstn(rstn), .rx_i(rx_i),
    .data_o(data_o), .valid_o(valid_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .frame_err_o(frame_err_o), .timeout_err_o(timeout_err_o), .busy_o(busy_o)
  );

  // ---- scoreboard ----
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_byte_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  part_q[$];
  int exp_ferr = 0;
  int exp_tout = 0;
  logic [31:0] model_data = '0;
  logic [7:0]  model_byte = '0;
  int n_valid = 0, n_ferr = 0, n_tout = 0, n_bytes = 0;
  logic [31:0] last_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse seen, none expected at %0t", name, $time);
  endtask

  // Byte-level view: good bytes accumulate four at a time, errors and long gaps drop the partial.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (ok) begin
      exp_byte_q.push_back(b);
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        exp_q.push_back({part_q[0], part_q[1], part_q[2], part_q[3]});
        part_q.delete();
      end
    end else begin
      exp_ferr++;
      part_q.delete();
    end
  endtask

  task automatic model_gap(input int gap);
    if (gap > 20 && part_q.size() != 0) begin
      exp_tout++;
      part_q.delete();
    end
  endtask

  task automatic model_reset();
    exp_byte_q.delete();
    exp_q.delete();
    part_q.delete();
    exp_ferr   = 0;
    exp_tout   = 0;
    model_data = '0;
    model_byte = '0;
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (byte_valid_o) begin
        n_bytes++;
        if (exp_byte_q.size() == 0) unexpected("byte_valid_o");
        else begin
          model_byte = exp_byte_q.pop_front();
          check("byte_o", byte_o, model_byte);
        end
      end
      if (valid_o) begin
        n_valid++;
        last_word = data_o;
        check("valid_with_byte", byte_valid_o, 1);
        if (exp_q.size() == 0) unexpected("valid_o");
        else begin
          model_data = exp_q.pop_front();
          check("word", data_o, model_data);
        end
      end
      if (frame_err_o) begin
        n_ferr++;
        if (exp_ferr == 0) unexpected("frame_err_o");
        else exp_ferr--;
      end
      if (timeout_err_o) begin
        n_tout++;
        if (exp_tout == 0) unexpected("timeout_err_o");
        else exp_tout--;
      end
      check("data_hold", data_o, model_data);
      check("byte_hold", byte_o, model_byte);
    end
  end

  // ---- driver tasks (called at posedge+1) ----
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok, input int gap);
    model_frame(b, ok);
    model_gap(gap);
    rx_i = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cycles(CPB);
    end
    rx_i = ok;
    wait_cycles(CPB);
    rx_i = 1'b1;
    if (gap > 0) wait_cycles(gap);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1, 0);
  endtask

  task automatic idle(input int n);
    model_gap(n);
    rx_i = 1'b1;
    wait_cycles(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_o"}, data_o, 0);
    check({tag, "_valid_o"}, valid_o, 0);
    check({tag, "_byte_o"}, byte_o, 0);
    check({tag, "_byte_valid_o"}, byte_valid_o, 0);
    check({tag, "_frame_err_o"}, frame_err_o, 0);
    check({tag, "_timeout_err_o"}, timeout_err_o, 0);
    check({tag, "_busy_o"}, busy_o, 0);
  endtask

  int v0, b0, f0, t0;
  task automatic snap();
    v0 = n_valid; b0 = n_bytes; f0 = n_ferr; t0 = n_tout;
  endtask

  initial begin
    rstn = 1'b0;
    rx_i = 1'b1;
    wait_cycles(3);
    check_all_zero("reset");
    rstn = 1'b1;
    idle(10);

    // 0x00,0x00,0x12,0x34 back-to-back
    snap();
    send_word(32'h00001234);
    idle(8);
    check("t1_word", last_word, 32'h00001234);
    check("t1_valid_cnt", n_valid - v0, 1);
    check("t1_byte_cnt", n_bytes - b0, 4);

    // two consecutive words
    snap();
    send_word(32'h56789ABC);
    check("t2_first_word", last_word, 32'h56789ABC);
    send_word(32'hDEADBEEF);
    idle(8);
    check("t2_word", last_word, 32'hDEADBEEF);
    check("t2_valid_cnt", n_valid - v0, 2);

    // short glitch while idle
    snap();
    rx_i = 1'b0;
    wait_cycles(2);
    idle(20);
    check("t3_glitch_busy", busy_o, 0);
    check("t3_glitch_bytes", n_bytes - b0, 0);
    send_word(32'h11223344);
    idle(8);
    check("t3_word", last_word, 32'h11223344);

    // frame error drops partial word
    snap();
    send_frame(8'hAA, 1'b1, 0);
    send_frame(8'hBB, 1'b1, 0);
    send_frame(8'h55, 1'b0, 10);
    send_word(32'h01020304);
    idle(8);
    check("t4_ferr_cnt", n_ferr - f0, 1);
    check("t4_valid_cnt", n_valid - v0, 1);
    check("t4_word", last_word, 32'h01020304);

    // timeout drops partial word
    snap();
    send_frame(8'h10, 1'b1, 0);
    idle(45);
    check("t5_tout_cnt", n_tout - t0, 1);
    send_word(32'hA1A2A3A4);
    idle(8);
    check("t5_word", last_word, 32'hA1A2A3A4);
    check("t5_valid_cnt", n_valid - v0, 1);

    // reset mid-bit of the 3rd byte
    send_frame(8'hCA, 1'b1, 0);
    send_frame(8'hFE, 1'b1, 0);
    rx_i = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 5; i++) begin
      rx_i = i[0];
      wait_cycles(CPB);
    end
    wait_cycles(3);
    rstn = 1'b0;
    rx_i = 1'b1;
    model_reset();
    wait_cycles(1);
    check_all_zero("midreset");
    rstn = 1'b1;
    idle(10);
    send_word(32'hCAFEF00D);
    idle(8);
    check("t6_word", last_word, 32'hCAFEF00D);

    // random frames: good bytes, occasional frame errors and long gaps
    for (int n = 0; n < 48; n++) begin
      logic [7:0] b;
      bit ok;
      int gap;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      if (!ok) gap = $urandom_range(8, 12);
      else if ($urandom_range(0, 7) == 0) gap = $urandom_range(40, 60);
      else gap = $urandom_range(0, 12);
      send_frame(b, ok, gap);
    end
    idle(60);

    check("end_bytes_pending", exp_byte_q.size(), 0);
    check("end_words_pending", exp_q.size(), 0);
    check("end_ferr_pending", exp_ferr, 0);
    check("end_tout_pending", exp_tout, 0);
    check("end_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
